// File: rtl/vga_timing_gen_if.sv
// Pixel stream into the VGA timing generator.
// valid/ready: a pixel moves when both are high.
interface vga_timing_gen_if #(
  parameter int PIX_W = 24
);
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;

  modport master (
    output pix_data,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/LCD timing generator.
// Stream or test-pattern pixels, one cycle registered.
module vga_timing_gen #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int PIX_W  = 24,
  localparam int XW    = $clog2(HDISP),
  localparam int YW    = $clog2(VDISP)
) (
  input  logic             pixel_clk,
  input  logic             pixel_rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] solid_rgb,
  vga_timing_gen_if.slave  pix,
  output logic             video_hs,
  output logic             video_vs,
  output logic             video_blank,
  output logic [PIX_W-1:0] video_rgb,
  output logic [XW-1:0]    pos_x,
  output logic [YW-1:0]    pos_y,
  output logic             frame_start,
  output logic             underflow,
  input  logic             underflow_clr,
  output logic [15:0]      frame_count
);

  localparam int HSTART = HFP + HPULSE + HBP;
  localparam int VSTART = VFP + VPULSE + VBP;
  localparam int HTOTAL = HDISP + HSTART;
  localparam int VTOTAL = VDISP + VSTART;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int CW     = PIX_W / 3;
  localparam int GXW    = (XW < 4) ? XW : 4;
  localparam int GYW    = (YW < 4) ? YW : 4;
  localparam int BARW   = (HDISP / 8 > 0) ? HDISP / 8 : 1;

  logic [HW-1:0]    h_cnt;
  logic [VW-1:0]    v_cnt;
  logic             hs_act;
  logic             vs_act;
  logic             act;
  logic             frame_top;
  logic             uf_set;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             grid;
  logic [2:0]       bar;
  logic [2:0]       bar_c;
  logic [PIX_W-1:0] bar_rgb;
  logic [PIX_W-1:0] rgb_next;
  logic [1:0]       mode_q;
  logic [PIX_W-1:0] solid_q;

  // Region decode and active coordinates
  always_comb begin
    hs_act    = (h_cnt >= HW'(HFP)) &&
                (h_cnt < HW'(HFP + HPULSE));
    vs_act    = (v_cnt >= VW'(VFP)) &&
                (v_cnt < VW'(VFP + VPULSE));
    act       = (h_cnt >= HW'(HSTART)) &&
                (v_cnt >= VW'(VSTART));
    frame_top = (h_cnt == '0) && (v_cnt == '0);
    x         = h_cnt[XW-1:0] - XW'(HSTART);
    y         = v_cnt[YW-1:0] - YW'(VSTART);
    pix.pix_ready = enable && !pixel_rst &&
                    act && (mode_q == 2'd0);
    uf_set    = pix.pix_ready && !pix.pix_valid;
  end

  // Test patterns: grid lines and 8 colour bars
  always_comb begin
    grid = (x[GXW-1:0] == '0) || (y[GYW-1:0] == '0);
    bar  = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (32'(x) >= 32'(i * BARW)) bar = 3'(i);
    end
    bar_c = 3'b000;
    unique case (bar)
      3'd0: bar_c = 3'b111;
      3'd1: bar_c = 3'b110;
      3'd2: bar_c = 3'b011;
      3'd3: bar_c = 3'b010;
      3'd4: bar_c = 3'b101;
      3'd5: bar_c = 3'b100;
      3'd6: bar_c = 3'b001;
      3'd7: bar_c = 3'b000;
    endcase
    bar_rgb = {{CW{bar_c[2]}},
               {CW{bar_c[1]}},
               {CW{bar_c[0]}}};
  end

  // Pixel source select, blanked outside active
  always_comb begin
    rgb_next = '0;
    if (act) begin
      unique case (mode_q)
        2'd0: if (pix.pix_valid) rgb_next = pix.pix_data;
        2'd1: rgb_next = grid ? '1 : '0;
        2'd2: rgb_next = bar_rgb;
        2'd3: rgb_next = solid_q;
      endcase
    end
  end

  // Pixel and line counters; parked at 0 when idle
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst || !enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HW'(HTOTAL - 1)) begin
      h_cnt <= '0;
      if (v_cnt == VW'(VTOTAL - 1)) v_cnt <= '0;
      else v_cnt <= v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Source select only changes at frame top
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      mode_q  <= 2'd0;
      solid_q <= '0;
    end else if (frame_top) begin
      mode_q  <= mode;
      solid_q <= solid_rgb;
    end
  end

  // Registered video outputs, all one cycle behind
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst || !enable) begin
      video_hs    <= !HS_POL;
      video_vs    <= !VS_POL;
      video_blank <= 1'b0;
      video_rgb   <= '0;
      pos_x       <= '0;
      pos_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      video_hs    <= hs_act ? HS_POL : !HS_POL;
      video_vs    <= vs_act ? VS_POL : !VS_POL;
      video_blank <= act;
      video_rgb   <= rgb_next;
      pos_x       <= act ? x : '0;
      pos_y       <= act ? y : '0;
      frame_start <= frame_top;
    end
  end

  // Frame counter and sticky underflow hold while idle
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      frame_count <= 16'd0;
      underflow   <= 1'b0;
    end else if (enable) begin
      if (frame_top) frame_count <= frame_count + 16'd1;
      if (uf_set) underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small 8x4 timing plus a
// default 800x480 build with inverted HS.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst1, en1, clr1;
  logic [1:0]  mode1;
  logic [23:0] sol1;
  logic        hs1, vs1, blank1, fs1, uf1;
  logic [23:0] rgb1;
  logic [2:0]  px1;
  logic [1:0]  py1;
  logic [15:0] fcnt1;

  logic        rst2, en2;
  logic [1:0]  mode2;
  logic        hs2, vs2, blank2, fs2, uf2;
  logic [23:0] rgb2;
  logic [9:0]  px2;
  logic [8:0]  py2;
  logic [15:0] fcnt2;

  vga_timing_gen_if #(.PIX_W(24)) pif1 ();
  vga_timing_gen_if #(.PIX_W(24)) pif2 ();

  vga_timing_gen #(
    .HDISP(8), .VDISP(4),
    .HFP(2), .HPULSE(2), .HBP(2),
    .VFP(1), .VPULSE(1), .VBP(1)
  ) dut1 (
    .pixel_clk(clk), .pixel_rst(rst1),
    .enable(en1), .mode(mode1),
    .solid_rgb(sol1), .pix(pif1),
    .video_hs(hs1), .video_vs(vs1),
    .video_blank(blank1), .video_rgb(rgb1),
    .pos_x(px1), .pos_y(py1),
    .frame_start(fs1), .underflow(uf1),
    .underflow_clr(clr1),
    .frame_count(fcnt1)
  );

  vga_timing_gen #(.HS_POL(1'b1)) dut2 (
    .pixel_clk(clk), .pixel_rst(rst2),
    .enable(en2), .mode(mode2),
    .solid_rgb(24'h0), .pix(pif2),
    .video_hs(hs2), .video_vs(vs2),
    .video_blank(blank2), .video_rgb(rgb2),
    .pos_x(px2), .pos_y(py2),
    .frame_start(fs2), .underflow(uf2),
    .underflow_clr(1'b0),
    .frame_count(fcnt2)
  );

  int          fc;
  bit          uf;
  logic [23:0] data;
  int          chg_c;
  logic [1:0]  chg_mode;
  logic [23:0] chg_sol;
  int          dacc;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bar_col(input int b);
    case (b)
      0: return 24'hffffff;
      1: return 24'hffff00;
      2: return 24'h00ffff;
      3: return 24'h00ff00;
      4: return 24'hff00ff;
      5: return 24'hff0000;
      6: return 24'h0000ff;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic bit f_act(input int n);
    return (n % 14 >= 6) && (n / 14 >= 3);
  endfunction

  function automatic logic [23:0] f_pat(
      input int m, input int c, input logic [23:0] s);
    int px;
    int py;
    if (!f_act(c)) return 24'h0;
    px = c % 14 - 6;
    py = c / 14 - 3;
    case (m)
      1: return (px % 16 == 0 || py % 16 == 0) ?
                24'hffffff : 24'h0;
      2: return bar_col(px);
      3: return s;
      default: return 24'h0;
    endcase
  endfunction

  task automatic apply_chg(input int c);
    if (c == chg_c) begin
      mode1 = chg_mode;
      sol1  = chg_sol;
      chg_c = -1;
    end
  endtask

  task automatic check_out(input int c,
                           input logic [23:0] er);
    int h;
    int v;
    bit a;
    h = c % 14;
    v = c / 14;
    a = f_act(c);
    if (c == 0) fc++;
    chk("hs", hs1, (h == 2 || h == 3) ? 0 : 1);
    chk("vs", vs1, (v == 1) ? 0 : 1);
    chk("blank", blank1, a);
    chk("rgb", rgb1, er);
    chk("pos_x", px1, a ? h - 6 : 0);
    chk("pos_y", py1, a ? v - 3 : 0);
    chk("frame_start", fs1, c == 0);
    chk("frame_count", fcnt1, fc);
    chk("underflow", uf1, uf);
  endtask

  task automatic check_reset;
    chk("rst_hs", hs1, 1);
    chk("rst_vs", vs1, 1);
    chk("rst_blank", blank1, 0);
    chk("rst_rgb", rgb1, 0);
    chk("rst_pos_x", px1, 0);
    chk("rst_pos_y", py1, 0);
    chk("rst_frame_start", fs1, 0);
    chk("rst_ready", pif1.pix_ready, 0);
    chk("rst_frame_count", fcnt1, fc);
    chk("rst_underflow", uf1, uf);
  endtask

  task automatic pattern_frame(input int m,
                               input logic [23:0] s,
                               input int len);
    for (int c = 0; c < len; c++) begin
      check_out(c, f_pat(m, c, s));
      apply_chg(c);
      chk("ready_idle", pif1.pix_ready, 0);
      tick();
    end
  endtask

  task automatic stream_frame(
      input int m0, input int m1, input int m2,
      input int k0, input int k1);
    logic [23:0] e;
    e = 24'h0;
    dacc = 0;
    for (int c = 0; c < 98; c++) begin
      int n;
      bit er;
      bit miss;
      n = (c + 1) % 98;
      check_out(c, e);
      apply_chg(c);
      miss = (n == m0 || n == m1 || n == m2);
      er = f_act(n);
      pif1.pix_valid = !miss;
      pif1.pix_data  = data;
      clr1 = (n == k0 || n == k1);
      chk("pix_ready", pif1.pix_ready, er);
      if (pif1.pix_ready && pif1.pix_valid) dacc++;
      e = (er && !miss) ? data : 24'h0;
      if (er && miss) uf = 1'b1;
      else if (clr1) uf = 1'b0;
      tick();
      if (er && !miss) data++;
      pif1.pix_valid = 1'b1;
      clr1 = 1'b0;
    end
  endtask

  initial begin
    int k;
    rst1 = 1'b1; en1 = 1'b0; clr1 = 1'b0;
    mode1 = 2'd3; sol1 = 24'h123456;
    pif1.pix_valid = 1'b0;
    pif1.pix_data = 24'h0;
    rst2 = 1'b1; en2 = 1'b0; mode2 = 2'd2;
    pif2.pix_valid = 1'b0;
    pif2.pix_data = 24'h0;
    fc = 0; uf = 1'b0; data = 24'h100;
    chg_c = -1; chg_mode = 2'd0; chg_sol = 24'h0;
    dacc = 0;

    repeat (3) tick();
    check_reset();

    rst1 = 1'b0; en1 = 1'b1;
    rst2 = 1'b0; en2 = 1'b1;
    pif1.pix_valid = 1'b1;
    tick();

    pattern_frame(3, 24'h123456, 98);

    chg_c = 5; chg_mode = 2'd0; chg_sol = 24'h123456;
    pattern_frame(3, 24'h123456, 98);

    stream_frame(-1, -1, -1, -1, -1);
    chk("accepts_full", dacc, 32);

    chg_c = 5; chg_mode = 2'd3; chg_sol = 24'h123456;
    stream_frame(48, 50, 62, 50, 55);
    chk("accepts_missed", dacc, 29);

    chg_c = 50; chg_mode = 2'd1; chg_sol = 24'habcdef;
    pattern_frame(3, 24'h123456, 98);

    chg_c = 40; chg_mode = 2'd2; chg_sol = 24'habcdef;
    pattern_frame(1, 24'habcdef, 98);

    pattern_frame(2, 24'habcdef, 98);
    pattern_frame(2, 24'habcdef, 20);

    en1 = 1'b0;
    repeat (5) begin
      tick();
      check_reset();
    end
    en1 = 1'b1;
    tick();
    pattern_frame(2, 24'habcdef, 30);

    rst1 = 1'b1;
    fc = 0;
    uf = 1'b0;
    tick();
    check_reset();
    tick();
    check_reset();
    rst1 = 1'b0;
    tick();
    pattern_frame(2, 24'habcdef, 98);

    k = 0;
    while (blank2 !== 1'b1 && k < 60000) begin
      tick();
      k++;
    end
    chk("big_reach_active", blank2, 1);
    for (int x = 0; x < 800; x++) begin
      if (x % 100 == 0 || x % 100 == 99) begin
        chk("big_bar_rgb", rgb2, bar_col(x / 100));
        chk("big_pos_x", px2, x);
        chk("big_pos_y", py2, 0);
      end
      tick();
    end
    chk("big_blank_end", blank2, 0);
    chk("big_hs_idle", hs2, 0);
    chk("big_vs_idle", vs2, 1);
    repeat (40) tick();
    chk("big_hs_pulse", hs2, 1);
    repeat (48) tick();
    chk("big_hs_after", hs2, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
